// File: rtl/picorv_pcpi_sched.sv
// PCPI request sequencer: broadcasts a latched request to NCOP coprocessors,
// forwards the lowest-index claim, or traps when nobody claims in time.
module picorv_pcpi_sched #(
    parameter int NCOP    = 4,
    parameter int XLEN    = 32,
    parameter int ILEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pcpi_valid,
    input  logic [ILEN-1:0]      pcpi_insn,
    input  logic [XLEN-1:0]      pcpi_rs1_data,
    input  logic [XLEN-1:0]      pcpi_rs2_data,
    output logic                 pcpi_ready,
    output logic                 pcpi_trap,
    output logic                 pcpi_wb_write,
    output logic [XLEN-1:0]      pcpi_wb_data,
    output logic                 pcpi_br_enable,
    output logic [XLEN-1:0]      pcpi_br_nextpc,
    input  logic [NCOP-1:0]      cop_enable,
    output logic [NCOP-1:0]      cop_valid,
    output logic [ILEN-1:0]      cop_insn,
    output logic [XLEN-1:0]      cop_rs1_data,
    output logic [XLEN-1:0]      cop_rs2_data,
    input  logic [NCOP-1:0]      cop_ready,
    input  logic [NCOP-1:0]      cop_wb_write,
    input  logic [NCOP*XLEN-1:0] cop_wb_data,
    input  logic [NCOP-1:0]      cop_br_enable,
    input  logic [NCOP*XLEN-1:0] cop_br_nextpc,
    output logic                 cop_collide
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [NCOP-1:0] cop_valid_q;
    logic [ILEN-1:0] insn_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            ready_q;
    logic            trap_q;
    logic            wb_write_q;
    logic [XLEN-1:0] wb_data_q;
    logic            br_enable_q;
    logic [XLEN-1:0] br_nextpc_q;
    logic            collide_q;

    logic [NCOP-1:0] hit_d;
    logic            multi_d;
    logic            found_d;
    logic            pick_wbw_d;
    logic [XLEN-1:0] pick_wbd_d;
    logic            pick_bre_d;
    logic [XLEN-1:0] pick_brpc_d;

    // Priority pick: lowest-index slot among those currently strobed.
    always_comb begin
        hit_d       = cop_ready & cop_valid_q;
        multi_d     = |(hit_d & (hit_d - NCOP'(1)));
        found_d     = 1'b0;
        pick_wbw_d  = 1'b0;
        pick_wbd_d  = '0;
        pick_bre_d  = 1'b0;
        pick_brpc_d = '0;
        for (int i = 0; i < NCOP; i++) begin
            if (hit_d[i] && !found_d) begin
                found_d     = 1'b1;
                pick_wbw_d  = cop_wb_write[i];
                pick_wbd_d  = cop_wb_data[i*XLEN +: XLEN];
                pick_bre_d  = cop_br_enable[i];
                pick_brpc_d = cop_br_nextpc[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cop_valid_q <= '0;
            insn_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ready_q     <= 1'b0;
            trap_q      <= 1'b0;
            wb_write_q  <= 1'b0;
            wb_data_q   <= '0;
            br_enable_q <= 1'b0;
            br_nextpc_q <= '0;
            collide_q   <= 1'b0;
        end else begin
            ready_q     <= 1'b0;
            trap_q      <= 1'b0;
            wb_write_q  <= 1'b0;
            wb_data_q   <= '0;
            br_enable_q <= 1'b0;
            br_nextpc_q <= '0;
            collide_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cop_valid_q <= '0;
                    if (pcpi_valid) begin
                        insn_q      <= pcpi_insn;
                        rs1_q       <= pcpi_rs1_data;
                        rs2_q       <= pcpi_rs2_data;
                        cnt_q       <= CW'(TIMEOUT);
                        cop_valid_q <= cop_enable;
                        state_q     <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (!pcpi_valid) begin
                        cop_valid_q <= '0;
                        state_q     <= IDLE;
                    end else if (found_d) begin
                        cop_valid_q <= '0;
                        ready_q     <= 1'b1;
                        wb_write_q  <= pick_wbw_d;
                        wb_data_q   <= pick_wbd_d;
                        br_enable_q <= pick_bre_d;
                        br_nextpc_q <= pick_brpc_d;
                        collide_q   <= multi_d;
                        state_q     <= DONE;
                    end else if (TIMEOUT != 0 && cnt_q == CW'(1)) begin
                        cop_valid_q <= '0;
                        ready_q     <= 1'b1;
                        trap_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cop_valid_q <= cop_enable;
                        if (TIMEOUT != 0) cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    cop_valid_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    cop_valid_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign pcpi_ready     = ready_q;
    assign pcpi_trap      = trap_q;
    assign pcpi_wb_write  = wb_write_q;
    assign pcpi_wb_data   = wb_data_q;
    assign pcpi_br_enable = br_enable_q;
    assign pcpi_br_nextpc = br_nextpc_q;
    assign cop_valid      = cop_valid_q;
    assign cop_insn       = insn_q;
    assign cop_rs1_data   = rs1_q;
    assign cop_rs2_data   = rs2_q;
    assign cop_collide    = collide_q;

endmodule

// File: tb/tb_picorv_pcpi_sched.sv
// Bench for picorv_pcpi_sched: directed vector table, async reset
// sequence and randomized transactions against a transaction-level model.
module tb_picorv_pcpi_sched;

    localparam int NCOP = 4;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int T    = 16;
    localparam int MAXC = T + 3;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 pcpi_valid;
    logic [ILEN-1:0]      pcpi_insn;
    logic [XLEN-1:0]      pcpi_rs1_data;
    logic [XLEN-1:0]      pcpi_rs2_data;
    logic                 pcpi_ready;
    logic                 pcpi_trap;
    logic                 pcpi_wb_write;
    logic [XLEN-1:0]      pcpi_wb_data;
    logic                 pcpi_br_enable;
    logic [XLEN-1:0]      pcpi_br_nextpc;
    logic [NCOP-1:0]      cop_enable;
    logic [NCOP-1:0]      cop_valid;
    logic [ILEN-1:0]      cop_insn;
    logic [XLEN-1:0]      cop_rs1_data;
    logic [XLEN-1:0]      cop_rs2_data;
    logic [NCOP-1:0]      cop_ready;
    logic [NCOP-1:0]      cop_wb_write;
    logic [NCOP*XLEN-1:0] cop_wb_data;
    logic [NCOP-1:0]      cop_br_enable;
    logic [NCOP*XLEN-1:0] cop_br_nextpc;
    logic                 cop_collide;

    always #5 clock = ~clock;

    picorv_pcpi_sched #(
        .NCOP(NCOP), .XLEN(XLEN), .ILEN(ILEN), .TIMEOUT(T)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .pcpi_valid(pcpi_valid),
        .pcpi_insn(pcpi_insn),
        .pcpi_rs1_data(pcpi_rs1_data),
        .pcpi_rs2_data(pcpi_rs2_data),
        .pcpi_ready(pcpi_ready),
        .pcpi_trap(pcpi_trap),
        .pcpi_wb_write(pcpi_wb_write),
        .pcpi_wb_data(pcpi_wb_data),
        .pcpi_br_enable(pcpi_br_enable),
        .pcpi_br_nextpc(pcpi_br_nextpc),
        .cop_enable(cop_enable),
        .cop_valid(cop_valid),
        .cop_insn(cop_insn),
        .cop_rs1_data(cop_rs1_data),
        .cop_rs2_data(cop_rs2_data),
        .cop_ready(cop_ready),
        .cop_wb_write(cop_wb_write),
        .cop_wb_data(cop_wb_data),
        .cop_br_enable(cop_br_enable),
        .cop_br_nextpc(cop_br_nextpc),
        .cop_collide(cop_collide)
    );

    typedef struct {
        logic [3:0]  en;
        int          pre_c;
        logic [3:0]  pre_v;
        int          k;
        logic [3:0]  v;
        int          ab;
        int          rc;
        int          last;
        logic        trap;
        logic        coll;
        logic        wbw;
        logic [31:0] wbd;
        logic        bre;
        logic [31:0] brpc;
    } vec_t;

    vec_t tbl [8];

    int checks = 0;
    int errors = 0;

    logic [3:0]  rdy_seq [0:MAXC];
    logic [31:0] wbd_s   [4];
    logic [31:0] brpc_s  [4];
    logic [3:0]  wbw_s;
    logic [3:0]  bre_s;

    int          e_rc;
    int          e_last;
    int          abort_c;
    logic        e_trap;
    logic        e_coll;
    logic        e_wbw;
    logic [31:0] e_wbd;
    logic        e_bre;
    logic [31:0] e_brpc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fixed_slots();
        wbd_s[0]  = 32'hA0A0_0000;
        wbd_s[1]  = 32'h0000_0011;
        wbd_s[2]  = 32'hDEAD_BEEF;
        wbd_s[3]  = 32'h0000_0033;
        brpc_s[0] = 32'h0000_1000;
        brpc_s[1] = 32'h0000_2001;
        brpc_s[2] = 32'h0000_2002;
        brpc_s[3] = 32'h0000_2003;
        wbw_s     = 4'b1110;
        bre_s     = 4'b0001;
    endtask

    task automatic load_vec(input int i);
        for (int c = 0; c <= MAXC; c++) rdy_seq[c] = 4'b0;
        if (tbl[i].pre_c != 0) rdy_seq[tbl[i].pre_c] = tbl[i].pre_v;
        if (tbl[i].k != 0) rdy_seq[tbl[i].k] = tbl[i].v;
        abort_c = tbl[i].ab;
        e_rc    = tbl[i].rc;
        e_last  = tbl[i].last;
        e_trap  = tbl[i].trap;
        e_coll  = tbl[i].coll;
        e_wbw   = tbl[i].wbw;
        e_wbd   = tbl[i].wbd;
        e_bre   = tbl[i].bre;
        e_brpc  = tbl[i].brpc;
    endtask

    // Transaction-level expectation: first enabled claim within the
    // timeout window wins unless the request is withdrawn first.
    task automatic model(input logic [3:0] en);
        int k;
        int lim;
        logic [3:0] m;
        int s;
        k = 0;
        for (int c = 1; c <= T; c++) begin
            if (k == 0 && (rdy_seq[c] & en) != 4'b0) k = c;
        end
        lim    = (k != 0) ? k : T;
        e_trap = 1'b0;
        e_coll = 1'b0;
        e_wbw  = 1'b0;
        e_wbd  = '0;
        e_bre  = 1'b0;
        e_brpc = '0;
        if (abort_c != 0 && abort_c <= lim) begin
            e_rc   = 0;
            e_last = abort_c;
        end else if (k != 0) begin
            m = rdy_seq[k] & en;
            s = -1;
            for (int i = 0; i < 4; i++) if (s < 0 && m[i]) s = i;
            e_rc   = k + 1;
            e_last = k;
            e_coll = ($countones(m) > 1);
            e_wbw  = wbw_s[s];
            e_wbd  = wbd_s[s];
            e_bre  = bre_s[s];
            e_brpc = brpc_s[s];
        end else begin
            e_rc   = T + 1;
            e_last = T;
            e_trap = 1'b1;
        end
    endtask

    task automatic drive_txn(input logic [3:0] en, input logic [31:0] insn,
                             input logic [31:0] rs1, input logic [31:0] rs2);
        logic [3:0] ev;
        pcpi_valid    = 1'b1;
        pcpi_insn     = insn;
        pcpi_rs1_data = rs1;
        pcpi_rs2_data = rs2;
        cop_enable    = en;
        cop_ready     = 4'b0;
        cop_wb_write  = wbw_s;
        cop_br_enable = bre_s;
        for (int i = 0; i < 4; i++) begin
            cop_wb_data[i*XLEN +: XLEN]   = wbd_s[i];
            cop_br_nextpc[i*XLEN +: XLEN] = brpc_s[i];
        end
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clock);
            #1;
            ev = (c <= e_last) ? en : 4'b0;
            chk("cop_valid", 32'(cop_valid), 32'(ev));
            chk("pcpi_ready", 32'(pcpi_ready), 32'(c == e_rc));
            chk("cop_collide", 32'(cop_collide), 32'(c == e_rc && e_coll));
            if (c == e_rc) begin
                chk("pcpi_trap", 32'(pcpi_trap), 32'(e_trap));
                chk("wb_write", 32'(pcpi_wb_write), 32'(e_wbw));
                chk("wb_data", pcpi_wb_data, e_wbd);
                chk("br_enable", 32'(pcpi_br_enable), 32'(e_bre));
                chk("br_nextpc", pcpi_br_nextpc, e_brpc);
            end else begin
                chk("idle_result",
                    32'(pcpi_trap || pcpi_wb_write || pcpi_br_enable ||
                        pcpi_wb_data != 0 || pcpi_br_nextpc != 0), 32'(0));
            end
            if (c == 1) begin
                chk("cop_insn", cop_insn, insn);
                chk("cop_rs1", cop_rs1_data, rs1);
                chk("cop_rs2", cop_rs2_data, rs2);
            end
            cop_ready = rdy_seq[c];
            if (abort_c != 0 && c >= abort_c) pcpi_valid = 1'b0;
            else if (e_rc != 0 && c >= e_rc) pcpi_valid = 1'b0;
            else pcpi_valid = 1'b1;
        end
        cop_ready  = 4'b0;
        pcpi_valid = 1'b0;
        chk("insn_hold", cop_insn, insn);
    endtask

    initial begin
        logic [3:0] en;
        tbl[0] = '{4'hF, 0, 4'h0, 3, 4'b0100, 0, 4, 3,
                   1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h2002};
        tbl[1] = '{4'hF, 0, 4'h0, 2, 4'b1010, 0, 3, 2,
                   1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'h2001};
        tbl[2] = '{4'hF, 0, 4'h0, 0, 4'b0000, 0, 17, 16,
                   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3] = '{4'b0001, 1, 4'b0010, 3, 4'b0001, 0, 4, 3,
                   1'b0, 1'b0, 1'b0, 32'hA0A0_0000, 1'b1, 32'h1000};
        tbl[4] = '{4'hF, 0, 4'h0, 2, 4'b0001, 2, 0, 2,
                   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[5] = '{4'hF, 0, 4'h0, 16, 4'b1000, 0, 17, 16,
                   1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 32'h2003};
        tbl[6] = '{4'h0, 2, 4'b1111, 0, 4'b0000, 0, 17, 16,
                   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{4'hF, 0, 4'h0, 1, 4'b0001, 0, 2, 1,
                   1'b0, 1'b0, 1'b0, 32'hA0A0_0000, 1'b1, 32'h1000};

        resetn        = 1'b0;
        pcpi_valid    = 1'b0;
        pcpi_insn     = '0;
        pcpi_rs1_data = '0;
        pcpi_rs2_data = '0;
        cop_enable    = '0;
        cop_ready     = '0;
        cop_wb_write  = '0;
        cop_wb_data   = '0;
        cop_br_enable = '0;
        cop_br_nextpc = '0;
        fixed_slots();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(pcpi_ready), 32'(0));
        chk("rst_valid", 32'(cop_valid), 32'(0));
        chk("rst_collide", 32'(cop_collide), 32'(0));
        chk("rst_insn", cop_insn, 32'(0));
        chk("rst_result",
            32'(pcpi_trap || pcpi_wb_write || pcpi_br_enable ||
                pcpi_wb_data != 0 || pcpi_br_nextpc != 0), 32'(0));
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            load_vec(i);
            drive_txn(tbl[i].en, 32'h0200_00B3 + 32'(i),
                      32'h1000 + 32'(i), 32'h2000 + 32'(i));
        end

        pcpi_valid    = 1'b1;
        pcpi_insn     = 32'h0AAA_0001;
        pcpi_rs1_data = 32'h5;
        pcpi_rs2_data = 32'h6;
        cop_enable    = 4'hF;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("pre_rst_valid", 32'(cop_valid), 32'hF);
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(cop_valid), 32'(0));
        chk("arst_ready", 32'(pcpi_ready), 32'(0));
        chk("arst_collide", 32'(cop_collide), 32'(0));
        chk("arst_insn", cop_insn, 32'(0));
        pcpi_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        load_vec(7);
        drive_txn(4'hF, 32'h0BBB_0002, 32'h7, 32'h8);

        for (int n = 0; n < 60; n++) begin
            en = 4'($urandom);
            for (int c = 0; c <= MAXC; c++)
                rdy_seq[c] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            abort_c = ($urandom_range(0, 4) == 0) ? $urandom_range(1, T) : 0;
            for (int i = 0; i < 4; i++) begin
                wbd_s[i]  = $urandom;
                brpc_s[i] = $urandom;
            end
            wbw_s = 4'($urandom);
            bre_s = 4'($urandom);
            model(en);
            drive_txn(en, $urandom, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
